// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ctrl_pkg                                                       |
// | Purpose : Shared constants for the pushbutton / switch command front     |
// |           end: input bit positions, default timing and the load-source   |
// |           encoding used by the command arbiter.                          |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package ctrl_pkg;

   // Pushbutton bit positions within btn_raw
   localparam int BTN_STEP = 0;
   localparam int BTN_LOAD = 1;
   localparam int BTN_CLR  = 2;
   localparam int BTN_MAX  = 3;

   // Switch bit positions within sw_raw
   localparam int SW_DIR   = 0;
   localparam int SW_RUN   = 1;

   localparam int NUM_BTN  = 4;
   localparam int NUM_SW   = 2;
   localparam int NUM_IN   = NUM_BTN + NUM_SW;

   // Default timing at a 125 MHz clock
   localparam int DEF_DB_CYCLES  = 1250000;   // 10 ms
   localparam int DEF_REPEAT_DLY = 62500000;  // 500 ms
   localparam int DEF_REPEAT_PER = 12500000;  // 100 ms
   localparam int DEF_RUN_DIV    = 12500000;  // 100 ms

   // Which source wins the load command in a given cycle
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_VAL  = 2'd1,
      SRC_MAX  = 2'd2,
      SRC_CLR  = 2'd3
   } load_src_t;

endpackage
`default_nettype wire

// File: rtl/btn_cmd_frontend_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : btn_cmd_frontend_if                                            |
// | Purpose : Bundles the raw operator inputs and the counter command        |
// |           outputs of btn_cmd_frontend.                                   |
// | Signals : btn_raw[3:0]  raw pushbuttons (step, load_val, clear, max)     |
// |           sw_raw[1:0]   raw switches (direction, run)                    |
// |           load_val[3:0] quasi-static load data                           |
// |           load          one-cycle load command                           |
// |           up_down       direction level (1 = up)                         |
// |           enable        one-cycle count command                          |
// |           d_in[3:0]     load data, valid while load is high              |
// | Modports: master drives the raw inputs, slave is the front end itself.   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface btn_cmd_frontend_if;
   logic [3:0] btn_raw;
   logic [1:0] sw_raw;
   logic [3:0] load_val;
   logic       load;
   logic       up_down;
   logic       enable;
   logic [3:0] d_in;

   modport master (
      output btn_raw, sw_raw, load_val,
      input  load, up_down, enable, d_in
   );

   modport slave (
      input  btn_raw, sw_raw, load_val,
      output load, up_down, enable, d_in
   );
endinterface
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : input_debounce                                                 |
// | Purpose : 2-FF synchroniser, stability counter and debounced state for   |
// |           one asynchronous input, plus a one-cycle rising-edge pulse.    |
// | Ports   : clk, rst     clock, synchronous active-high reset              |
// |           raw_i        asynchronous input                                |
// |           db_o         debounced level                                   |
// |           rise_o       one-cycle pulse, coincident with db_o going high  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module input_debounce #(
   parameter int DB_CYCLES = 1250000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic db_o,
   output logic rise_o
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          db_q;
   logic          rise_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b00;
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw_i};
         rise_q <= 1'b0;
         if (sync_q[1] == db_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            // The DB_CYCLES-th consecutive mismatch: accept the new level.
            // The edge pulse is registered here, alongside db, so the
            // command stage downstream adds only one more flop of latency.
            db_q   <= sync_q[1];
            rise_q <= sync_q[1];
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign db_o   = db_q;
   assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/btn_cmd_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : btn_cmd_frontend                                               |
// | Purpose : Turns raw pushbuttons and switches into clean, registered      |
// |           load / enable / direction commands for an up/down counter,    |
// |           with step auto-repeat and a free-running run mode.             |
// | Ports   : clk, rst  clock, synchronous active-high reset                 |
// |           bus       btn_cmd_frontend_if.slave (raw inputs, commands)     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module btn_cmd_frontend
   import ctrl_pkg::*;
#(
   parameter int DB_CYCLES  = DEF_DB_CYCLES,
   parameter int REPEAT_DLY = DEF_REPEAT_DLY,
   parameter int REPEAT_PER = DEF_REPEAT_PER,
   parameter int RUN_DIV    = DEF_RUN_DIV
) (
   input  logic               clk,
   input  logic               rst,
   btn_cmd_frontend_if.slave  bus
);

   localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam int RUN_W   = $clog2(RUN_DIV + 1);

   logic [NUM_IN-1:0] raw_vec;
   logic [NUM_IN-1:0] db;
   logic [NUM_IN-1:0] rise;

   assign raw_vec = {bus.sw_raw, bus.btn_raw};

   generate
      for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
         input_debounce #(
            .DB_CYCLES (DB_CYCLES)
         ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (raw_vec[i]),
            .db_o   (db[i]),
            .rise_o (rise[i])
         );
      end
   endgenerate

   // Switch edges and the levels of the load buttons carry no command.
   logic unused_deb;
   assign unused_deb = ^{rise[NUM_IN-1:NUM_BTN], db[BTN_MAX:BTN_LOAD]};

   logic [REP_W-1:0] rep_cnt_q;
   logic             rep_first_q;
   logic [RUN_W-1:0] run_cnt_q;
   logic             load_q, enable_q, up_down_q;
   logic [3:0]       d_in_q;

   load_src_t        load_src;
   logic             load_d, enable_d;
   logic [3:0]       d_in_d;
   logic [REP_W-1:0] rep_tgt;
   logic             rep_req, run_req, step_req;

   always_comb begin
      // Repeat counter reads k in the k-th cycle after the press pulse,
      // so matching the target directly gives the requested spacing.
      rep_tgt  = rep_first_q ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_PER);
      step_req = rise[BTN_STEP];
      rep_req  = db[BTN_STEP] && !rise[BTN_STEP] && (rep_cnt_q == rep_tgt);
      run_req  = db[NUM_BTN + SW_RUN] && (run_cnt_q == RUN_W'(RUN_DIV - 1));

      load_src = SRC_NONE;
      if (rise[BTN_CLR])       load_src = SRC_CLR;
      else if (rise[BTN_MAX])  load_src = SRC_MAX;
      else if (rise[BTN_LOAD]) load_src = SRC_VAL;

      load_d = (load_src != SRC_NONE);
      case (load_src)
         SRC_CLR: d_in_d = 4'h0;
         SRC_MAX: d_in_d = 4'hF;
         SRC_VAL: d_in_d = bus.load_val;
         default: d_in_d = d_in_q;
      endcase

      // A load takes the cycle; any count request then is discarded.
      enable_d = (step_req || rep_req || run_req) && !load_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_q      <= 1'b0;
         enable_q    <= 1'b0;
         up_down_q   <= 1'b0;
         d_in_q      <= 4'h0;
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b1;
         run_cnt_q   <= '0;
      end else begin
         load_q    <= load_d;
         enable_q  <= enable_d;
         d_in_q    <= d_in_d;
         up_down_q <= db[NUM_BTN + SW_DIR];

         if (!db[BTN_STEP] || rise[BTN_STEP]) begin
            rep_cnt_q   <= rise[BTN_STEP] ? REP_W'(1) : '0;
            rep_first_q <= 1'b1;
         end else if (rep_req) begin
            rep_cnt_q   <= REP_W'(1);
            rep_first_q <= 1'b0;
         end else if (rep_cnt_q != '1) begin
            rep_cnt_q <= rep_cnt_q + REP_W'(1);
         end

         if (!db[NUM_BTN + SW_RUN] || run_req) begin
            run_cnt_q <= '0;
         end else if (run_cnt_q != '1) begin
            run_cnt_q <= run_cnt_q + RUN_W'(1);
         end
      end
   end

   assign bus.load    = load_q;
   assign bus.enable  = enable_q;
   assign bus.up_down = up_down_q;
   assign bus.d_in    = d_in_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_cmd_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_btn_cmd_frontend                                            |
// | Purpose : Directed self-checking bench for btn_cmd_frontend with short   |
// |           timing (DB=4, REPEAT_DLY=20, REPEAT_PER=5, RUN_DIV=8).         |
// |           Inputs change and outputs are sampled on the falling edge;     |
// |           "k" counts rising edges since the input change.                |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_btn_cmd_frontend;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   btn_cmd_frontend_if ifc ();

   btn_cmd_frontend #(
      .DB_CYCLES  (4),
      .REPEAT_DLY (20),
      .REPEAT_PER (5),
      .RUN_DIV    (8)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      ifc.btn_raw  = 4'h0;
      ifc.sw_raw   = 2'b00;
      ifc.load_val = 4'h5;
      cyc(3);
      check("rst_load",   {3'b0, ifc.load},    4'h0);
      check("rst_enable", {3'b0, ifc.enable},  4'h0);
      check("rst_updown", {3'b0, ifc.up_down}, 4'h0);
      check("rst_din",    ifc.d_in,            4'h0);
      rst = 1'b0;
      cyc(10);

      // max + load_val pressed together: max wins, one load with F
      ifc.btn_raw = 4'b1010;
      for (int k = 1; k <= 10; k++) begin
         cyc(1);
         check($sformatf("mx_load k=%0d", k), {3'b0, ifc.load}, (k == 7) ? 4'h1 : 4'h0);
         check($sformatf("mx_din k=%0d", k), ifc.d_in, (k >= 7) ? 4'hF : 4'h0);
         check($sformatf("mx_en k=%0d", k), {3'b0, ifc.enable}, 4'h0);
      end
      ifc.btn_raw = 4'b0000;
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         check($sformatf("mx_rel k=%0d", k), {ifc.load, ifc.enable, 2'b00}, 4'h0);
      end

      // clear press: load with 0 at k=7, enable never
      ifc.btn_raw = 4'b0100;
      for (int k = 1; k <= 10; k++) begin
         cyc(1);
         check($sformatf("clr_load k=%0d", k), {3'b0, ifc.load}, (k == 7) ? 4'h1 : 4'h0);
         check($sformatf("clr_din k=%0d", k), ifc.d_in, (k >= 7) ? 4'h0 : 4'hF);
         check($sformatf("clr_en k=%0d", k), {3'b0, ifc.enable}, 4'h0);
      end
      ifc.btn_raw = 4'b0000;
      cyc(12);

      // load_val button bouncing 1,0,1,0 then held, load_val = A
      ifc.load_val = 4'hA;
      for (int b = 0; b < 4; b++) begin
         ifc.btn_raw = (b % 2 == 0) ? 4'b0010 : 4'b0000;
         cyc(1);
         check($sformatf("bnc_pre b=%0d", b), {3'b0, ifc.load}, 4'h0);
      end
      ifc.btn_raw = 4'b0010;
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         check($sformatf("bnc_load k=%0d", k), {3'b0, ifc.load}, (k == 7) ? 4'h1 : 4'h0);
         check($sformatf("bnc_din k=%0d", k), ifc.d_in, (k >= 7) ? 4'hA : 4'h0);
      end
      ifc.btn_raw = 4'b0000;
      cyc(12);

      // step held 60 cycles: enable at 7, 27, then every 5 while held
      ifc.btn_raw = 4'b0001;
      for (int k = 1; k <= 80; k++) begin
         cyc(1);
         check($sformatf("rep_en k=%0d", k), {3'b0, ifc.enable},
               ((k == 7) || (k >= 27 && k <= 62 && (k - 27) % 5 == 0)) ? 4'h1 : 4'h0);
         check($sformatf("rep_load k=%0d", k), {3'b0, ifc.load}, 4'h0);
         if (k == 60) ifc.btn_raw = 4'b0000;
      end
      cyc(5);

      // run + up: enable every 8 from k=14; clear load at k=22 kills that tick
      ifc.sw_raw = 2'b11;
      for (int k = 1; k <= 60; k++) begin
         cyc(1);
         check($sformatf("run_en k=%0d", k), {3'b0, ifc.enable},
               (k >= 14 && k <= 46 && (k - 14) % 8 == 0 && k != 22) ? 4'h1 : 4'h0);
         check($sformatf("run_load k=%0d", k), {3'b0, ifc.load}, (k == 22) ? 4'h1 : 4'h0);
         check($sformatf("run_dir k=%0d", k), {3'b0, ifc.up_down},
               (k >= 7 && k < 47) ? 4'h1 : 4'h0);
         check($sformatf("run_din k=%0d", k), ifc.d_in, (k >= 22) ? 4'h0 : 4'hA);
         if (k == 15) ifc.btn_raw = 4'b0100;
         if (k == 30) ifc.btn_raw = 4'b0000;
         if (k == 40) ifc.sw_raw  = 2'b00;
      end

      // preload d_in=F and up_down=1 so reset has visible work to do
      ifc.btn_raw = 4'b1000;
      ifc.sw_raw  = 2'b01;
      cyc(8);
      check("pre_din", ifc.d_in, 4'hF);
      check("pre_dir", {3'b0, ifc.up_down}, 4'h1);
      ifc.btn_raw = 4'b0000;
      cyc(12);

      // reset in the middle of a step debounce
      ifc.btn_raw = 4'b0001;
      cyc(3);
      rst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cyc(1);
         check($sformatf("mid_rst k=%0d", k),
               {ifc.load, ifc.enable, ifc.up_down, 1'b0}, 4'h0);
         check($sformatf("mid_rst_din k=%0d", k), ifc.d_in, 4'h0);
      end
      rst = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         cyc(1);
         check($sformatf("post_en k=%0d", k), {3'b0, ifc.enable},
               (k == 7 || k == 27) ? 4'h1 : 4'h0);
         check($sformatf("post_load k=%0d", k), {3'b0, ifc.load}, 4'h0);
         check($sformatf("post_dir k=%0d", k), {3'b0, ifc.up_down}, (k >= 7) ? 4'h1 : 4'h0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
